decode_out_packer: RTL and testbench
====================================

// Module: decode_out_packer
// PURPOSE
//  Parametrised output packer for the LZS decode datapath. Packs the decoder's
//  byte stream into DATA_W-bit words, little-endian: byte lane 0 is [7:0].
//  Buffers completed words in a DEPTH-entry FIFO with ready/valid backpressure.
//  Closes partial words on end-of-stream, with per-lane keep and a last flag.
// PARAMETERS
//  DATA_W     64    output word width; multiple of 8, >=16; NB = DATA_W/8 lanes
//  DEPTH      4     output FIFO depth in words; power of 2, >=2
//  PAD        8'hFF fill byte for unused lanes of a partial word
//  EMPTY_LAST 1     1: flush with no pending bytes emits keep=0,last=1 word
// PORTS
//  clk        in  1      clock, rising edge
//  rst        in  1      reset, asynchronous, active-high
//  in_data    in  8      decoded byte
//  in_valid   in  1      in_data valid
//  in_last    in  1      byte is final byte of stream (qualified by in_valid)
//  in_ready   out 1      byte/flush accepted this cycle when high
//  flush      in  1      level request: close stream now (decoder source drained)
//  flush_ack  out 1      one-cycle pulse: flush consumed
//  m_data     out DATA_W packed word (FIFO head)
//  m_keep     out NB     lane valid mask, bit i = lane i
//  m_last     out 1      word ends stream
//  m_valid    out 1      FIFO non-empty
//  m_ready    in  1      sink accepts word
//  busy       out 1      pos!=0 or FIFO non-empty
//  eos_done   out 1      level: a last word has been popped; cleared on next byte accept
// BEHAVIOUR
//  Reset: pos=0, FIFO empty, in_ready=1, m_valid=0, m_data=0, m_keep=0,
//   m_last=0, flush_ack=0, busy=0, eos_done=0. Reset mid-operation discards the
//   partial word and all FIFO contents; no word is emitted.
//  Outputs m_data/m_keep/m_last are forced 0 whenever m_valid=0.
//  in_ready = (count < DEPTH). No write-through when full: a same-cycle pop
//   frees space only in the next cycle.
//  Byte accept (in_valid & in_ready): byte written into lane pos of the
//   assembly register, then pos++.
//   Lanes above pos in the assembly register hold PAD.
//  Word push, in the accept cycle; the word is visible at m_valid next cycle:
//   - pos==NB-1 accepted without end: keep all ones, last=0, pos->0.
//   - in_last, or flush while ready, with a byte accept: word includes the
//     byte, keep = (1<<(pos+1))-1, last=1, pos->0.
//   - flush while ready, no byte, pos!=0: keep = (1<<pos)-1, last=1, pos->0.
//   - flush while ready, no byte, pos==0: if EMPTY_LAST push data=all PAD,
//     keep=0, last=1; else no push.
//  Flush is honoured only while in_ready=1; the requester holds flush until
//   flush_ack. flush_ack pulses in the consuming cycle.
//  flush with in_valid&in_last in the same cycle: exactly one last word;
//   flush_ack still pulses.
//  At most one push per cycle.
//  Pop on m_valid & m_ready; FIFO pointers wrap modulo DEPTH.
//   count width is clog2(DEPTH)+1.
//  eos_done sets on the cycle after popping a last=1 word; it clears on the
//   first subsequent byte accept.
//  Latency: byte in at cycle N (completing a word) -> m_valid at N+1.
//   Sustained throughput: 1 byte/cycle in, 1 word per NB cycles out.
// TESTING
//  1 DATA_W=64, m_ready=1, bytes 01..08 -> one word 64'h0807060504030201,
//    keep=FF, last=0, m_valid one cycle after byte 08.
//  2 Bytes AA,BB,CC with in_last on CC -> 64'hFFFFFFFFFFCCBBAA, keep=07,
//    last=1; eos_done=1 after pop; clears when next byte is accepted.
//  3 flush at pos=0: EMPTY_LAST=1 -> data all FF, keep=00, last=1;
//    EMPTY_LAST=0 -> no word; flush_ack pulses in both cases.
//  4 DEPTH=4, m_ready=0, 40 bytes offered -> in_ready=0 after 32 accepted;
//    raise m_ready -> 4 words in order, remaining 8 bytes then accepted, no loss.
//  5 rst pulsed after 5 bytes -> m_valid=0, busy=0; next 8 bytes 10..17 ->
//    clean word 64'h1716151413121110, keep=FF.
//  6 pos=2, flush and in_valid (byte 33, in_last=0) same cycle -> single word
//    keep=07, last=1, lane 2 = 33; one flush_ack.

Source files
------------

// File: rtl/decode_out_packer.sv
// Byte-to-word output packer for the LZS decode datapath: assembles decoded bytes
// little-endian into DATA_W words and queues them in a small ready/valid FIFO.
module decode_out_packer #(
  parameter int         DATA_W     = 64,
  parameter int         DEPTH      = 4,
  parameter logic [7:0] PAD        = 8'hFF,
  parameter bit         EMPTY_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              flush,
  output logic              flush_ack,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              eos_done
);

  localparam int NB    = DATA_W / 8;
  localparam int POS_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: in_data is taken on a clock edge where in_valid & in_ready; a
  // flush request is consumed on an edge where flush & in_ready (flush_ack high
  // that cycle); a word leaves on an edge where m_valid & m_ready. in_ready
  // reflects only the registered FIFO count, so a pop never frees space in the
  // same cycle.

  // Assembly state
  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  pos_d;
  logic [DATA_W-1:0] asm_q;

  // FIFO state
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [NB-1:0]     mem_keep [DEPTH];
  logic              mem_last [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              eos_q;

  // Per-cycle controls
  logic              accept;
  logic              flush_take;
  logic              pos_full;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic [NB-1:0]     push_keep;
  logic              push_last;

  function automatic logic [NB-1:0] lane_mask(input int n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  assign in_ready   = (count_q < CNT_W'(DEPTH));
  assign accept     = in_valid & in_ready;
  assign flush_take = flush & in_ready;
  assign pos_full   = (pos_q == POS_W'(NB - 1));
  assign m_valid    = (count_q != '0);
  assign pop        = m_valid & m_ready;
  assign flush_ack  = flush_take;
  assign busy       = (pos_q != '0) | m_valid;
  assign eos_done   = eos_q;

  // Word closing decision; at most one push per cycle.
  always_comb begin
    push_data = asm_q;
    push_keep = '0;
    push_last = 1'b0;
    push      = 1'b0;
    pos_d     = pos_q;
    if (accept) begin
      push_data[int'(pos_q)*8 +: 8] = in_data;
    end
    if (accept) begin
      if (in_last | flush) begin
        push      = 1'b1;
        push_keep = lane_mask(int'(pos_q) + 1);
        push_last = 1'b1;
        pos_d     = '0;
      end else if (pos_full) begin
        push      = 1'b1;
        push_keep = '1;
        pos_d     = '0;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end else if (flush_take) begin
      if (pos_q != '0) begin
        push      = 1'b1;
        push_keep = lane_mask(int'(pos_q));
        push_last = 1'b1;
        pos_d     = '0;
      end else if (EMPTY_LAST) begin
        push      = 1'b1;
        push_data = {NB{PAD}};
        push_keep = '0;
        push_last = 1'b1;
      end
    end
  end

  // Assembly register: unwritten lanes always carry PAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      asm_q <= {NB{PAD}};
    end else begin
      pos_q <= pos_d;
      if (push) begin
        asm_q <= {NB{PAD}};
      end else if (accept) begin
        asm_q[int'(pos_q)*8 +: 8] <= in_data;
      end
    end
  end

  // FIFO storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_keep[wr_ptr_q] <= push_keep;
      mem_last[wr_ptr_q] <= push_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A last-word pop in the same cycle as a byte accept leaves eos_done set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eos_q <= 1'b0;
    end else begin
      if (accept) begin
        eos_q <= 1'b0;
      end
      if (pop && mem_last[rd_ptr_q]) begin
        eos_q <= 1'b1;
      end
    end
  end

  assign m_data = m_valid ? mem_data[rd_ptr_q] : '0;
  assign m_keep = m_valid ? mem_keep[rd_ptr_q] : '0;
  assign m_last = m_valid ? mem_last[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_decode_out_packer.sv
// Directed bench for decode_out_packer: per-cycle vector table plus hand-written
// sequences for backpressure, reset mid-word and EMPTY_LAST=0 flush.
module tb_decode_out_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        flush;
  logic        flush_ack;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        eos_done;

  logic        flush_ne;
  logic        flush_ack_ne;
  logic        in_ready_ne;
  logic [63:0] m_data_ne;
  logic [7:0]  m_keep_ne;
  logic        m_last_ne;
  logic        m_valid_ne;
  logic        busy_ne;
  logic        eos_done_ne;

  int checks = 0;
  int errors = 0;

  decode_out_packer #(.DATA_W(64), .DEPTH(4), .PAD(8'hFF), .EMPTY_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .flush(flush), .flush_ack(flush_ack), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .eos_done(eos_done)
  );

  decode_out_packer #(.DATA_W(64), .DEPTH(4), .PAD(8'hFF), .EMPTY_LAST(1'b0)) dut_ne (
    .clk(clk), .rst(rst), .in_data(8'h00), .in_valid(1'b0), .in_last(1'b0),
    .in_ready(in_ready_ne), .flush(flush_ne), .flush_ack(flush_ack_ne), .m_data(m_data_ne),
    .m_keep(m_keep_ne), .m_last(m_last_ne), .m_valid(m_valid_ne), .m_ready(1'b1),
    .busy(busy_ne), .eos_done(eos_done_ne)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        lst;
    logic        fl;
    logic        mr;
    logic        e_mv;
    logic [63:0] e_md;
    logic [7:0]  e_mk;
    logic        e_ml;
    logic        e_rdy;
    logic        e_ack;
    logic        e_busy;
    logic        e_eos;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] exp_q[$];

  function automatic vec_t v(logic vld, logic [7:0] dat, logic lst, logic fl, logic mr,
                             logic e_mv, logic [63:0] e_md, logic [7:0] e_mk, logic e_ml,
                             logic e_rdy, logic e_ack, logic e_busy, logic e_eos);
    vec_t r;
    r.vld = vld; r.dat = dat; r.lst = lst; r.fl = fl; r.mr = mr;
    r.e_mv = e_mv; r.e_md = e_md; r.e_mk = e_mk; r.e_ml = e_ml;
    r.e_rdy = e_rdy; r.e_ack = e_ack; r.e_busy = e_busy; r.e_eos = e_eos;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] dat, input logic lst,
                       input logic fl, input logic mr);
    in_valid = vld; in_data = dat; in_last = lst; flush = fl; m_ready = mr;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 8'h00, 1'b0, 1'b0, m_ready);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [63:0] w;
    string tag;

    rst = 1'b1;
    flush_ne = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Vector table: inputs for one cycle and the outputs expected before its edge.
    vecs.push_back(v(1, 8'h01, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 0));
    for (int i = 2; i <= 8; i++)
      vecs.push_back(v(1, 8'(i), 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  1, 64'h0807060504030201, 8'hFF, 0,  1, 0, 1, 0));
    vecs.push_back(v(1, 8'hAA, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 0));
    vecs.push_back(v(1, 8'hBB, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 1, 0));
    vecs.push_back(v(1, 8'hCC, 1, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  1, 64'hFFFFFFFFFFCCBBAA, 8'h07, 1,  1, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 1));
    vecs.push_back(v(1, 8'h55, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 1));
    vecs.push_back(v(1, 8'h66, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 1, 0));
    vecs.push_back(v(1, 8'h33, 0, 1, 1,  0, 64'h0, 8'h00, 0,  1, 1, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  1, 64'hFFFFFFFFFF336655, 8'h07, 1,  1, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 1,  0, 64'h0, 8'h00, 0,  1, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1,  1, 0, 1, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 1));
    vecs.push_back(v(1, 8'h44, 1, 1, 1,  0, 64'h0, 8'h00, 0,  1, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  1, 64'hFFFFFFFFFFFFFF44, 8'h01, 1,  1, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1,  0, 64'h0, 8'h00, 0,  1, 0, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_keep", 64'(m_keep), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_flush_ack", 64'(flush_ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_eos_done", 64'(eos_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].dat, vecs[i].lst, vecs[i].fl, vecs[i].mr);
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'(vecs[i].e_mv));
      chk({tag, "_m_data"}, m_data, vecs[i].e_md);
      chk({tag, "_m_keep"}, 64'(m_keep), 64'(vecs[i].e_mk));
      chk({tag, "_m_last"}, 64'(m_last), 64'(vecs[i].e_ml));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(vecs[i].e_rdy));
      chk({tag, "_flush_ack"}, 64'(flush_ack), 64'(vecs[i].e_ack));
      chk({tag, "_busy"}, 64'(busy), 64'(vecs[i].e_busy));
      chk({tag, "_eos_done"}, 64'(eos_done), 64'(vecs[i].e_eos));
    end

    // Flush at pos 0 with EMPTY_LAST=0: acknowledged, nothing emitted.
    @(negedge clk);
    idle_inputs();
    flush_ne = 1'b1;
    #1;
    chk("ne_flush_ack", 64'(flush_ack_ne), 64'(1));
    @(negedge clk);
    flush_ne = 1'b0;
    #1;
    chk("ne_no_word", 64'(m_valid_ne), 64'(0));
    chk("ne_busy", 64'(busy_ne), 64'(0));
    @(negedge clk);
    #1;
    chk("ne_no_word_late", 64'(m_valid_ne), 64'(0));

    // Backpressure: 40 bytes offered against a stalled sink.
    for (int wi = 0; wi < 5; wi++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(wi*8 + b);
      exp_q.push_back(w);
    end
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive(sent < 40, 8'(sent), 1'b0, 1'b0, 1'b0);
      #1;
      if (in_valid && in_ready) sent++;
    end
    chk("bp_accepted", 64'(sent), 64'(32));
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    chk("bp_m_valid", 64'(m_valid), 64'(1));

    cyc = 0;
    while ((sent < 40 || exp_q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      drive(sent < 40, 8'(sent), 1'b0, 1'b0, 1'b1);
      #1;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_word", 64'(m_valid), 64'(0));
        end else begin
          w = exp_q.pop_front();
          chk("bp_word_data", m_data, w);
          chk("bp_word_keep", 64'(m_keep), 64'hFF);
          chk("bp_word_last", 64'(m_last), 64'(0));
        end
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("bp_all_sent", 64'(sent), 64'(40));
    chk("bp_queue_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    idle_inputs();
    #1;
    chk("bp_empty_after", 64'(m_valid), 64'(0));

    // Reset in the middle of a word.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_m_data", m_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
      #1;
      chk("post_rst_no_word", 64'(m_valid), 64'(0));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_m_valid", 64'(m_valid), 64'(1));
    chk("post_rst_m_data", m_data, 64'h1716151413121110);
    chk("post_rst_m_keep", 64'(m_keep), 64'hFF);
    chk("post_rst_m_last", 64'(m_last), 64'(0));
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_drained", 64'(m_valid), 64'(0));
    chk("post_rst_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
